ahb_sram_slave: RTL

- Parametrised AHB-Lite slave fronting a byte-addressable on-chip SRAM; successor to the 8-bit single-mode memory controller.
- Supports DATA_WIDTH-wide data with HSIZE byte/halfword/word (up to bus width) lane selection and little-endian byte strobes.
- Adds programmable wait states and a two-cycle ERROR response for illegal transfers.
- Sits on the AHB-Lite slave side of the interconnect; HREADY is returned from the mux.

---
 rtl/ahb_sram_slave_pkg.sv | 65 ++++++
 rtl/ahb_sram_slave_array.sv | 42 ++++
 rtl/ahb_sram_slave.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// ahb_sram_slave_pkg
// Shared definitions for the AHB-Lite SRAM slave: bus encodings, transfer
// sizes, the data-phase FSM state type and helpers used to size the array
// address and to build little-endian byte-lane strobes.
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } Trans_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } Response_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } BType_t;

  typedef enum logic [2:0] {
    BYTE  = 3'd0,
    HALF  = 3'd1,
    WORD  = 3'd2,
    DWORD = 3'd3
  } Size_t;

  // Data-phase state of the slave; exported so checkers can bind to it.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Address width for an array of n entries, never narrower than one bit.
  function automatic int addr_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-lane strobes for a transfer of 2**size bytes starting at lane
  // addr_lsbs. Sized for the widest (64-bit) bus; callers keep the low lanes.
  function automatic logic [7:0] lane_strobe(input logic [2:0] addr_lsbs,
                                             input logic [2:0] size);
    logic [7:0] base;
    case (size)
      3'd0:    base = 8'h01;
      3'd1:    base = 8'h03;
      3'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << addr_lsbs;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_array.sv
// ahb_sram_array
// Byte-enabled word storage for the SRAM slave. Writes are synchronous with
// one enable per byte lane; the read port is purely combinational.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   be     per-lane byte enables (lane 0 = bits 7:0)
//   waddr  word address of the write
//   wdata  write data
//   raddr  word address of the read
//   rdata  read data (combinational)
module ahb_sram_array
  import ahb_sram_slave_pkg::*;
#(
  parameter int MEM_BYTES  = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int LANES     = DATA_WIDTH / 8,
  localparam int WORDS     = MEM_BYTES / LANES,
  localparam int WA        = addr_bits(WORDS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [WA-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [WA-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// AHB-Lite slave in front of a byte-addressable on-chip SRAM. Supports
// byte/halfword/word/doubleword transfers up to the bus width, optional
// wait states on every OKAY data phase and a two-cycle ERROR response for
// out-of-range, oversized or misaligned transfers.
// Ports:
//   HCLK, HRESETn        clock and synchronous active-low reset
//   HSEL, HADDR, HTRANS  address-phase select, byte address, transfer type
//   HWRITE, HSIZE        direction and log2 transfer size
//   HBURST, HPROT,
//   HMASTLOCK            accepted but not used
//   HREADY               bus ready from the interconnect mux
//   HWDATA               write data (data phase)
//   HREADYOUT, HRESP     slave ready and response
//   HRDATA               read data, zero outside a read ACCESS cycle
//
// Handshake: an address phase is taken at a rising edge only when
// HSEL & HREADY and HTRANS is NONSEQ or SEQ; a data phase completes at the
// first rising edge where HREADYOUT is high.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_BYTES   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(LANES);
  localparam int WORDS     = MEM_BYTES / LANES;
  localparam int WA        = addr_bits(WORDS);

  state_t          state, state_n;
  logic [3:0]      wait_cnt, wait_cnt_n;
  logic            cap_en;
  logic            write_q;
  logic [WA-1:0]   addr_q;
  logic [LANES-1:0] be_q;

  Trans_t          htrans_t;
  logic            capture;
  logic            illegal;
  logic [2:0]      lane_off;
  logic [7:0]      strobe_full;
  logic [WA-1:0]   haddr_word;
  Response_t       hresp_e;
  logic            mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic            unused_ok;

  assign htrans_t = Trans_t'(HTRANS);
  // SEQ and NONSEQ are handled identically: every beat carries its address.
  assign capture  = HSEL && HREADY && (htrans_t == NONSEQ || htrans_t == SEQ);

  assign illegal = (64'(HADDR) >= 64'(MEM_BYTES))
                 || (int'(HSIZE) > LANE_BITS)
                 || (|(8'(HADDR) & ((8'd1 << HSIZE) - 8'd1)));

  assign lane_off    = 3'(HADDR) & 3'(LANES - 1);
  assign strobe_full = lane_strobe(lane_off, HSIZE);
  assign haddr_word  = WA'(HADDR >> LANE_BITS);

  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, strobe_full};

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      be_q     <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (cap_en) begin
        write_q <= HWRITE;
        addr_q  <= haddr_word;
        be_q    <= strobe_full[LANES-1:0];
      end
    end
  end

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    cap_en     = 1'b0;
    HREADYOUT  = 1'b1;
    hresp_e    = OKAY;
    unique case (state)
      // Every state that completes a data phase may take the next address.
      ST_IDLE, ST_ACCESS, ST_ERR2: begin
        if (state == ST_ERR2) hresp_e = ERROR;
        if (capture) begin
          cap_en = 1'b1;
          if (illegal) begin
            state_n = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_n    = ST_WAIT;
            wait_cnt_n = 4'(WAIT_STATES - 1);
          end else begin
            state_n = ST_ACCESS;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == 4'd0) state_n = ST_ACCESS;
        else                  wait_cnt_n = wait_cnt - 4'd1;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        hresp_e   = ERROR;
        state_n   = ST_ERR2;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // The write lands on the edge that closes ACCESS; a read captured on that
  // same edge sees the new data through the combinational read port.
  assign mem_we = (state == ST_ACCESS) && write_q;
  assign HRESP  = hresp_e;
  assign HRDATA = (state == ST_ACCESS && !write_q) ? mem_rdata : '0;

  ahb_sram_array #(
    .MEM_BYTES  (MEM_BYTES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (be_q),
    .waddr (addr_q),
    .wdata (HWDATA),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

endmodule
